fifo_wptr_full: RTL and testbench



---
 rtl/fifo_wptr_full_if.sv | 33 +++
 rtl/fifo_wptr_full.sv | 93 +++++++++
 tb/tb_fifo_wptr_full.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/fifo_wptr_full_if.sv
// Write-side bus of the async FIFO write-pointer block.
// walmost_full exists only when FIFO_WPTR_ALMOST_FULL_EN is defined.
interface fifo_wptr_full_if #(
  parameter int ADDRSIZE = 4
);
  logic                winc;
  logic [ADDRSIZE:0]   rptr;
  logic                wovf_clr;
  logic [ADDRSIZE-1:0] waddr;
  logic [ADDRSIZE:0]   wptr;
  logic                wfull;
  logic [ADDRSIZE:0]   wlevel;
  logic                wovf;
`ifdef FIFO_WPTR_ALMOST_FULL_EN
  logic                walmost_full;
`endif

  modport master (
    output winc, rptr, wovf_clr,
    input  waddr, wptr, wfull, wlevel, wovf
`ifdef FIFO_WPTR_ALMOST_FULL_EN
    , input walmost_full
`endif
  );

  modport slave (
    input  winc, rptr, wovf_clr,
    output waddr, wptr, wfull, wlevel, wovf
`ifdef FIFO_WPTR_ALMOST_FULL_EN
    , output walmost_full
`endif
  );
endinterface

// File: rtl/fifo_wptr_full.sv
// Write-domain pointer, full flag, fill level and sticky overflow for the async FIFO.
// Optional almost-full output enabled by defining FIFO_WPTR_ALMOST_FULL_EN.
module fifo_wptr_full #(
  parameter int ADDRSIZE  = 4,
  parameter int AF_MARGIN = 2
) (
  input  logic               wclk,
  input  logic               wrst_n,
  fifo_wptr_full_if.slave    bus
);
  localparam int DEPTH = 1 << ADDRSIZE;

  logic [ADDRSIZE:0] wq1_reg;
  logic [ADDRSIZE:0] wq2_reg;
  logic [ADDRSIZE:0] wbin_reg;
  logic [ADDRSIZE:0] wptr_reg;
  logic [ADDRSIZE:0] wlevel_reg;
  logic              wfull_reg;
  logic              wovf_reg;

  logic              acc;
  logic [ADDRSIZE:0] wbin_next;
  logic [ADDRSIZE:0] wgray_next;
  logic [ADDRSIZE:0] rbin_s;
  logic [ADDRSIZE:0] full_cmp;
  logic [ADDRSIZE:0] level_next;
  logic              wfull_next;
  logic              wovf_next;

  assign acc        = bus.winc & ~wfull_reg;
  assign wbin_next  = wbin_reg + {{ADDRSIZE{1'b0}}, acc};
  assign wgray_next = wbin_next ^ (wbin_next >> 1);

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  generate
    for (genvar gi = 0; gi <= ADDRSIZE; gi++) begin : g_g2b
      assign rbin_s[gi] = ^wq2_reg[ADDRSIZE:gi];
    end
  endgenerate

  assign full_cmp   = {~wq2_reg[ADDRSIZE:ADDRSIZE-1], wq2_reg[ADDRSIZE-2:0]};
  assign wfull_next = (wgray_next == full_cmp);
  assign level_next = wbin_next - rbin_s;

  always_comb begin
    wovf_next = wovf_reg;
    if (bus.winc & wfull_reg)
      wovf_next = 1'b1;
    else if (bus.wovf_clr)
      wovf_next = 1'b0;
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wq1_reg    <= '0;
      wq2_reg    <= '0;
      wbin_reg   <= '0;
      wptr_reg   <= '0;
      wfull_reg  <= 1'b0;
      wlevel_reg <= '0;
      wovf_reg   <= 1'b0;
    end else begin
      wq1_reg    <= bus.rptr;
      wq2_reg    <= wq1_reg;
      wbin_reg   <= wbin_next;
      wptr_reg   <= wgray_next;
      wfull_reg  <= wfull_next;
      wlevel_reg <= level_next;
      wovf_reg   <= wovf_next;
    end
  end

  assign bus.waddr  = wbin_reg[ADDRSIZE-1:0];
  assign bus.wptr   = wptr_reg;
  assign bus.wfull  = wfull_reg;
  assign bus.wlevel = wlevel_reg;
  assign bus.wovf   = wovf_reg;

`ifdef FIFO_WPTR_ALMOST_FULL_EN
  localparam logic [ADDRSIZE:0] AF_THRESH = (ADDRSIZE+1)'(DEPTH - AF_MARGIN);

  logic walmost_full_reg;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n)
      walmost_full_reg <= 1'b0;
    else
      walmost_full_reg <= (level_next >= AF_THRESH);
  end

  assign bus.walmost_full = walmost_full_reg;
`endif
endmodule

// File: tb/tb_fifo_wptr_full.sv
// Randomized self-checking bench for fifo_wptr_full against a count-based occupancy model.
module tb_fifo_wptr_full;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic wclk = 1'b0;
  logic wrst_n = 1'b0;
  always #5 wclk = ~wclk;

  fifo_wptr_full_if #(.ADDRSIZE(AW)) bus ();

  fifo_wptr_full #(.ADDRSIZE(AW), .AF_MARGIN(2)) dut (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .bus    (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Bench-side totals: words accepted (model) and words consumed by the reader.
  int r_total = 0;

  function automatic logic [AW:0] to_gray(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: occupancy = accepted count minus the read count the writer could have
  // seen, which is the reader's count as it stood two write-clock edges earlier.
  logic [AW:0] m_w;
  logic [AW:0] rd_seen [2];
  logic        m_full, m_ovf, m_af;
  logic [AW:0] m_level;
  int          m_total;

  always @(posedge wclk or negedge wrst_n) begin
    logic        acc;
    logic [AW:0] occ;
    if (!wrst_n) begin
      m_w = '0; m_full = 0; m_ovf = 0; m_af = 0; m_level = '0; m_total = 0;
      rd_seen[0] = '0; rd_seen[1] = '0;
    end else begin
      acc = bus.winc && !m_full;
      if (bus.winc && m_full) m_ovf = 1'b1;
      else if (bus.wovf_clr)  m_ovf = 1'b0;
      m_w = m_w + (AW+1)'(acc);
      if (acc) m_total++;
      occ     = m_w - rd_seen[1];
      m_full  = (occ == (AW+1)'(DEPTH));
      m_level = occ;
      m_af    = (occ >= (AW+1)'(DEPTH - 2));
      rd_seen[1] = rd_seen[0];
      rd_seen[0] = (AW+1)'(r_total);
    end
  end

  // Per-cycle compare on the falling edge, plus the one-bit Gray-step invariant.
  logic [AW:0] prev_wptr;
  logic        prev_ok = 1'b0;
  always @(negedge wclk) begin
    check("waddr",  32'(bus.waddr),  32'(m_w[AW-1:0]));
    check("wptr",   32'(bus.wptr),   32'(to_gray(m_w)));
    check("wfull",  32'(bus.wfull),  32'(m_full));
    check("wlevel", 32'(bus.wlevel), 32'(m_level));
    check("wovf",   32'(bus.wovf),   32'(m_ovf));
`ifdef FIFO_WPTR_ALMOST_FULL_EN
    check("walmost_full", 32'(bus.walmost_full), 32'(m_af));
`endif
    if (wrst_n && prev_ok)
      check("gray_step_le1", 32'($countones(prev_wptr ^ bus.wptr) <= 1), 32'd1);
    prev_wptr = bus.wptr;
    prev_ok   = wrst_n;
  end

  always_comb bus.rptr = to_gray((AW+1)'(r_total));

  // Inputs change 1 time unit after a rising edge and are sampled on the next one.
  task automatic cyc(input logic w, input logic clr);
    bus.winc     = w;
    bus.wovf_clr = clr;
    @(posedge wclk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.winc = 0; bus.wovf_clr = 0;
    // Reset held with winc toggling
    @(posedge wclk); #1;
    for (int i = 0; i < 6; i++) begin
      cyc(1'(i % 2), 1'b0);
      check("rst_wptr", 32'(bus.wptr), 32'h0);
      check("rst_waddr", 32'(bus.waddr), 32'h0);
    end
    wrst_n = 1'b1;
    check("first_waddr", 32'(bus.waddr), 32'h0);

    // Fill 16 words with the reader parked at 0
    for (int i = 0; i < DEPTH; i++) begin
      check("fill_waddr", 32'(bus.waddr), 32'(i));
      cyc(1'b1, 1'b0);
    end
    check("fill_wfull", 32'(bus.wfull), 32'd1);
    check("fill_wptr", 32'(bus.wptr), 32'b11000);
    check("fill_wlevel", 32'(bus.wlevel), 32'd16);

    // Overflow set / clear / set-wins
    cyc(1'b1, 1'b0);
    check("ovf_wptr", 32'(bus.wptr), 32'b11000);
    check("ovf_set", 32'(bus.wovf), 32'd1);
    cyc(1'b0, 1'b1);
    check("ovf_clr", 32'(bus.wovf), 32'd0);
    cyc(1'b1, 1'b1);
    check("ovf_set_wins", 32'(bus.wovf), 32'd1);
    cyc(1'b0, 1'b1);

    // Release: reader consumes one word, full drops on the third edge
    r_total = 1;
    cyc(1'b0, 1'b0);
    check("rel_edge1", 32'(bus.wfull), 32'd1);
    cyc(1'b0, 1'b0);
    check("rel_edge2", 32'(bus.wfull), 32'd1);
    cyc(1'b0, 1'b0);
    check("rel_edge3", 32'(bus.wfull), 32'd0);
    check("rel_wlevel", 32'(bus.wlevel), 32'd15);

    // Catch the reader up to a lag of 4, then 40 writes with the reader trailing
    while (r_total < m_total - 4) begin
      r_total++;
      cyc(1'b0, 1'b0);
    end
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1, 1'b0);
      r_total++;
      check("wrap_not_full", 32'(bus.wfull), 32'd0);
    end

    // Randomized traffic: reader never passes the accepted count
    for (int i = 0; i < 600; i++) begin
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0));
      if (r_total < m_total && $urandom_range(0, 9) < 4) r_total++;
    end

    // Fill to full, then async reset between edges
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    for (int i = 0; i < 40 && !m_full; i++) cyc(1'b1, 1'b0);
    check("pre_rst_wfull", 32'(bus.wfull), 32'd1);
    check("pre_rst_wlevel", 32'(bus.wlevel), 32'd16);
    #2;
    wrst_n  = 1'b0;
    r_total = 0;
    #1;
    check("arst_wptr", 32'(bus.wptr), 32'h0);
    check("arst_waddr", 32'(bus.waddr), 32'h0);
    check("arst_wfull", 32'(bus.wfull), 32'd0);
    check("arst_wlevel", 32'(bus.wlevel), 32'd0);
    check("arst_wovf", 32'(bus.wovf), 32'd0);
    @(posedge wclk); #1;
    wrst_n = 1'b1;
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0);
    check("post_rst_waddr", 32'(bus.waddr), 32'd5);
    cyc(1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
